arf_error_monitor: RTL and testbench

Synthesizable error-statistics accumulator that sits directly downstream of the ARF datapath pair (approximate `arf_er` and `arf_accurate`). Each accepted beat carries one output of the approximate filter and the matching output of the accurate filter for both output channels, ch0 = out_27 and ch1 = out_28. The block accumulates per-channel error sum, squared-error sum, |accurate| sum, exact-match count and high-bit-match count over a programmed number of samples. Results are read back through a registered read port, so on-chip/FPGA runs produce the same mean/variance/ER figures the simulation flow computes.

---
 rtl/arf_error_monitor_if.sv | 16 +
 rtl/arf_error_monitor.sv | 198 +++++++++++++++++++
 tb/tb_arf_error_monitor.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/arf_error_monitor_if.sv
// Beat bus between the ARF datapath pair and the error monitor.
// Latency: none, wires only.
// Backpressure: the source holds a beat while in_valid is high and in_ready is low.
interface arf_error_monitor_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] var0;
  logic [W-1:0] acc0;
  logic [W-1:0] var1;
  logic [W-1:0] acc1;

  modport master (output in_valid, var0, acc0, var1, acc1, input in_ready);
  modport slave  (input in_valid, var0, acc0, var1, acc1, output in_ready);
endinterface

// File: rtl/arf_error_monitor.sv
// Accumulates per-channel error statistics between approximate and accurate ARF outputs.
// Latency: 3 edges from beat acceptance to accumulator update; readout 1 cycle.
// Backpressure: in_ready only in RUN while fewer than N beats accepted; 1 beat/cycle.
module arf_error_monitor #(
  parameter int W         = 32,
  parameter int ER_THRESH = 8,
  parameter int NS_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NS_W-1:0]     num_samples,
  arf_error_monitor_if.slave  bus,
  output logic                busy,
  output logic                done,
  input  logic                rd_ch,
  input  logic [2:0]          rd_sel,
  output logic [2*W+15:0]     rd_data
);

  localparam int RW = 2*W + 16;
  localparam int EW = W + NS_W + 1;
  localparam int SW = 2*W + NS_W;
  localparam int AW = W + NS_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Per-channel stage payload; err is a two's-complement W+1 bit difference.
  typedef struct packed {
    logic [W:0]     err;
    logic [W-1:0]   a;
    logic           eq;
    logic           hi;
  } s1_t;

  typedef struct packed {
    logic [W:0]     err;
    logic [W-1:0]   a;
    logic           eq;
    logic           hi;
    logic [2*W+1:0] sq;
  } s2_t;

  state_t          state;
  logic [NS_W-1:0] n_reg;
  logic [NS_W-1:0] accepted;
  logic            s1_vld, s2_vld;
  s1_t             s1 [2];
  s2_t             s2 [2];
  s1_t             s1_d [2];
  logic [2*W+1:0]  sq_d [2];
  logic [W-1:0]    v_in [2];
  logic [W-1:0]    a_in [2];
  logic [EW-1:0]   sum_err [2];
  logic [SW-1:0]   sum_sq [2];
  logic [AW-1:0]   sum_abs [2];
  logic [NS_W-1:0] n_eq [2];
  logic [NS_W-1:0] n_hi [2];
  logic [RW-1:0]   rd_d;
  logic            start_ok;
  logic            take;

  assign v_in[0] = bus.var0;
  assign a_in[0] = bus.acc0;
  assign v_in[1] = bus.var1;
  assign a_in[1] = bus.acc1;

  // start is only honoured when no run is in progress
  assign start_ok     = start && (state == IDLE || state == DONE);
  assign bus.in_ready = (state == RUN) && (accepted < n_reg);
  assign take         = bus.in_valid && bus.in_ready;

  // S1 and S2 datapath: difference, magnitude, compares, then the square
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      s1_d[c].err = {v_in[c][W-1], v_in[c]} - {a_in[c][W-1], a_in[c]};
      // -2^(W-1) maps to 2^(W-1), which still fits W unsigned bits
      s1_d[c].a   = a_in[c][W-1] ? ({W{1'b0}} - a_in[c]) : a_in[c];
      s1_d[c].eq  = (v_in[c] == a_in[c]);
      s1_d[c].hi  = (v_in[c][W-1:ER_THRESH] == a_in[c][W-1:ER_THRESH]);
      // low 2W+2 bits of the sign-extended product are exactly err^2
      sq_d[c]     = {{(W+1){s1[c].err[W]}}, s1[c].err} * {{(W+1){s1[c].err[W]}}, s1[c].err};
    end
  end

  // Run-control FSM with registered busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_reg    <= '0;
      accepted <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_reg    <= num_samples;
            accepted <= '0;
            if (num_samples == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (take) accepted <= accepted + {{(NS_W-1){1'b0}}, 1'b1};
          if (accepted == n_reg) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_vld && !s2_vld) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two pipeline stages shared by both channels of a beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        s1[c] <= '0;
        s2[c] <= '0;
      end
    end else if (start_ok) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= take;
      s2_vld <= s1_vld;
      for (int c = 0; c < 2; c++) begin
        if (take) s1[c] <= s1_d[c];
        if (s1_vld) s2[c] <= {s1[c].err, s1[c].a, s1[c].eq, s1[c].hi, sq_d[c]};
      end
    end
  end

  // S3: accumulators, sized so a full-length run cannot overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        sum_err[c] <= '0;
        sum_sq[c]  <= '0;
        sum_abs[c] <= '0;
        n_eq[c]    <= '0;
        n_hi[c]    <= '0;
      end
    end else if (start_ok) begin
      for (int c = 0; c < 2; c++) begin
        sum_err[c] <= '0;
        sum_sq[c]  <= '0;
        sum_abs[c] <= '0;
        n_eq[c]    <= '0;
        n_hi[c]    <= '0;
      end
    end else if (s2_vld) begin
      for (int c = 0; c < 2; c++) begin
        sum_err[c] <= sum_err[c] + {{(NS_W){s2[c].err[W]}}, s2[c].err};
        sum_sq[c]  <= sum_sq[c] + SW'(s2[c].sq);
        sum_abs[c] <= sum_abs[c] + {{(NS_W){1'b0}}, s2[c].a};
        n_eq[c]    <= n_eq[c] + {{(NS_W-1){1'b0}}, s2[c].eq};
        n_hi[c]    <= n_hi[c] + {{(NS_W-1){1'b0}}, s2[c].hi};
      end
    end
  end

  // Readout field select; sum_err is the only signed field
  always_comb begin
    rd_d = '0;
    case (rd_sel)
      3'd0: rd_d = RW'(accepted);
      3'd1: rd_d = RW'(n_eq[rd_ch]);
      3'd2: rd_d = RW'(n_hi[rd_ch]);
      3'd3: rd_d = RW'($signed(sum_err[rd_ch]));
      3'd4: rd_d = RW'(sum_sq[rd_ch]);
      3'd5: rd_d = RW'(sum_abs[rd_ch]);
      default: rd_d = '0;
    endcase
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_d;
  end

endmodule

// File: tb/tb_arf_error_monitor.sv
// Directed bench for arf_error_monitor with hand-computed expected statistics.
// Latency: checks done timing 3 edges after the last acceptance and 1-cycle readout.
// Backpressure: drives in_valid patterns and checks in_ready against expected values.
module tb_arf_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        busy, done;
  logic        rd_ch = 1'b0;
  logic [2:0]  rd_sel = 3'd0;
  logic [79:0] rd_data;
  int          checks = 0;
  int          errors = 0;

  arf_error_monitor_if #(.W(32)) bus ();

  arf_error_monitor #(.W(32), .ER_THRESH(8), .NS_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .rd_ch       (rd_ch),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input string tag, input logic ch, input logic [2:0] sel,
                      input logic [79:0] exp);
    rd_ch  = ch;
    rd_sel = sel;
    tick;
    chk(tag, rd_data, exp);
  endtask

  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    tick;
    start       = 1'b0;
  endtask

  // Present a beat and hold it until it transfers; in_valid stays high afterwards.
  task automatic send(input logic [31:0] v0, input logic [31:0] a0,
                      input logic [31:0] v1, input logic [31:0] a1);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.var0 = v0;
    bus.acc0 = a0;
    bus.var1 = v1;
    bus.acc1 = a1;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        tick;
        ok = 1'b1;
        break;
      end
      tick;
    end
    chk("send_accepted", ok, 1);
  endtask

  task automatic wait_done;
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      tick;
    end
    chk("wait_done", done, 1);
  endtask

  logic [79:0] neg8;

  initial begin
    neg8 = ~80'd7;
    bus.in_valid = 1'b0;
    bus.var0 = '0;
    bus.acc0 = '0;
    bus.var1 = '0;
    bus.acc1 = '0;

    // Reset values
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    #10 rst_n = 1'b1;
    tick;

    // Exact match, back-to-back beats, done 3 edges after the last acceptance
    do_start(16'd4);
    chk("t1_busy", busy, 1);
    send(32'd5, 32'd5, 32'd5, 32'd5);
    send(32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9);
    send(32'd0, 32'd0, 32'd0, 32'd0);
    send(32'd100, 32'd100, 32'd100, 32'd100);
    bus.in_valid = 1'b0;
    chk("t1_ready_after_last", bus.in_ready, 0);
    tick;
    chk("t1_done_e1", done, 0);
    tick;
    chk("t1_done_e2", done, 0);
    chk("t1_busy_e2", busy, 1);
    tick;
    chk("t1_done_e3", done, 1);
    chk("t1_busy_e3", busy, 0);
    rchk("t1_accepted", 1'b0, 3'd0, 80'd4);
    rchk("t1_n_eq0", 1'b0, 3'd1, 80'd4);
    rchk("t1_n_hi0", 1'b0, 3'd2, 80'd4);
    rchk("t1_sum_err0", 1'b0, 3'd3, 80'd0);
    rchk("t1_sum_sq0", 1'b0, 3'd4, 80'd0);
    rchk("t1_sum_abs0", 1'b0, 3'd5, 80'd112);
    rchk("t1_n_eq1", 1'b1, 3'd1, 80'd4);
    rchk("t1_sum_abs1", 1'b1, 3'd5, 80'd112);
    rchk("t1_sel6", 1'b0, 3'd6, 80'd0);

    // Signed error on both channels
    do_start(16'd2);
    send(32'd10, 32'd13, 32'd3, 32'd10);
    send(32'hFFFFFFFB, 32'hFFFFFFF7, 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    wait_done;
    rchk("t2_sum_err0", 1'b0, 3'd3, 80'd1);
    rchk("t2_sum_sq0", 1'b0, 3'd4, 80'd25);
    rchk("t2_n_eq0", 1'b0, 3'd1, 80'd0);
    rchk("t2_n_hi0", 1'b0, 3'd2, 80'd2);
    rchk("t2_sum_abs0", 1'b0, 3'd5, 80'd22);
    rchk("t2_sum_err1", 1'b1, 3'd3, neg8);
    rchk("t2_sum_sq1", 1'b1, 3'd4, 80'd50);

    // Extremes on ch0, high bits differing on ch1
    do_start(16'd1);
    send(32'h7FFFFFFF, 32'h80000000, 32'h00000100, 32'h000000FF);
    bus.in_valid = 1'b0;
    wait_done;
    rchk("t3_sum_err0", 1'b0, 3'd3, 80'hFFFF_FFFF);
    rchk("t3_sum_sq0", 1'b0, 3'd4, 80'hFFFF_FFFE_0000_0001);
    rchk("t3_sum_abs0", 1'b0, 3'd5, 80'h8000_0000);
    rchk("t3_n_hi0", 1'b0, 3'd2, 80'd0);
    rchk("t3_n_hi1", 1'b1, 3'd2, 80'd0);
    rchk("t3_sum_err1", 1'b1, 3'd3, 80'd1);

    // High bits equal with low bits differing
    do_start(16'd1);
    send(32'd0, 32'd0, 32'h000001FF, 32'h00000100);
    bus.in_valid = 1'b0;
    wait_done;
    rchk("t4_n_hi1", 1'b1, 3'd2, 80'd1);
    rchk("t4_n_eq1", 1'b1, 3'd1, 80'd0);
    rchk("t4_sum_err1", 1'b1, 3'd3, 80'hFF);

    // Toggling in_valid, 5 beats offered, start pulse in DRAIN ignored
    do_start(16'd3);
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.var0 = 32'(i);
      bus.acc0 = 32'd0;
      bus.var1 = 32'd0;
      bus.acc1 = 32'd0;
      start = (i == 6);
      num_samples = 16'd7;
      chk($sformatf("t5_in_ready_%0d", i), bus.in_ready, (i <= 4) ? 1 : 0);
      tick;
      start = 1'b0;
      if (i == 6) begin
        chk("t5_done_e2", done, 0);
        chk("t5_busy_e2", busy, 1);
      end
      if (i == 7) chk("t5_done_e3", done, 1);
    end
    bus.in_valid = 1'b0;
    rchk("t5_accepted", 1'b0, 3'd0, 80'd3);
    rchk("t5_sum_err0", 1'b0, 3'd3, 80'd6);

    // Zero-length run
    do_start(16'd0);
    chk("t6_done", done, 1);
    chk("t6_busy", busy, 0);
    rchk("t6_accepted", 1'b0, 3'd0, 80'd0);
    rchk("t6_sum_err0", 1'b0, 3'd3, 80'd0);
    rchk("t6_sum_abs0", 1'b0, 3'd5, 80'd0);

    // Reset after 2 of 5 beats
    rd_ch  = 1'b0;
    rd_sel = 3'd0;
    do_start(16'd5);
    send(32'd7, 32'd1, 32'd0, 32'd0);
    send(32'd7, 32'd1, 32'd0, 32'd0);
    chk("t7_rd_before_rst", rd_data, 80'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_in_ready", bus.in_ready, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_done", done, 0);
    chk("t7_rst_rd_data", rd_data, 0);
    #2 rst_n = 1'b1;
    bus.in_valid = 1'b0;
    tick;
    rchk("t7_accepted_idle", 1'b0, 3'd0, 80'd0);
    rchk("t7_sum_err_idle", 1'b0, 3'd3, 80'd0);
    do_start(16'd1);
    send(32'd20, 32'd3, 32'd0, 32'd0);
    bus.in_valid = 1'b0;
    wait_done;
    rchk("t7_accepted", 1'b0, 3'd0, 80'd1);
    rchk("t7_sum_err0", 1'b0, 3'd3, 80'd17);
    rchk("t7_sum_sq0", 1'b0, 3'd4, 80'd289);
    rchk("t7_sum_abs0", 1'b0, 3'd5, 80'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
